// File: rtl/rsfq_merge_pkg.sv
// rsfq_merge_pkg: shared types and helpers for the RSFQ merger model.
// State encoding, dead-time counter width and a saturating adder used by
// the optional drop counter (enabled with RSFQ_MERGE_DROP_CNT_EN).
package rsfq_merge_pkg;

    // Merger control states: INIT swallows the input levels at reset release,
    // IDLE forwards pulses, DEAD absorbs pulses during the recovery window.
    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        DEAD = 2'd2
    } merge_state_t;

    // Width of the dead-time counter; holds DEAD_CYCLES values 0..15.
    localparam int DEAD_W = 4;

    // Saturating add of a small increment onto a counter value. The sum is
    // formed one bit wider so that an overflow past 32 bits cannot wrap
    // before the saturation compare sees it.
    function automatic logic [31:0] sat_add(
        input logic [31:0] cnt,
        input logic [1:0]  inc,
        input logic [31:0] maxVal
    );
        logic [32:0] sum;
        sum = {1'b0, cnt} + {31'b0, inc};
        if (sum > {1'b0, maxVal}) begin
            return maxVal;
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/rsfq_toggle_edge.sv
// rsfq_toggle_edge: converts a toggle-encoded SFQ line into a one-cycle
// event flag. The previous level is always tracked; the enable input lets
// the parent suppress events on the first edge after reset release.
module rsfq_toggle_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_tgl,
    input  logic i_en,
    output logic o_ev
);

    logic r_prev;

    // Track the last sampled level so any level change reads as one pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_tgl;
        end
    end

    assign o_ev = i_en & (i_tgl ^ r_prev);

endmodule

// File: rtl/rsfq_merge_toggle.sv
// rsfq_merge_toggle: clocked behavioural model of an RSFQ merger.
// Two toggle-encoded inputs are merged onto one toggle-encoded output with a
// configurable dead time; pulses that collapse into another are flagged.
// Optional feature macro: RSFQ_MERGE_DROP_CNT_EN adds the drop_cnt port, a
// saturating count of absorbed pulses.
module rsfq_merge_toggle #(
    parameter int DEAD_CYCLES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_tgl,
    input  logic             b_tgl,
    input  logic             clr_coll,
    output logic             q_tgl,
    output logic             q_pulse,
    output logic             busy,
    output logic             collision
`ifdef RSFQ_MERGE_DROP_CNT_EN
   ,output logic [CNT_W-1:0] drop_cnt
`endif
);

    import rsfq_merge_pkg::*;

    // Out-of-range parameters would silently truncate the dead counter or
    // break the saturation arithmetic, so stop elaboration instead.
    if (DEAD_CYCLES < 0 || DEAD_CYCLES > 15) begin : g_badDeadCycles
        $error("rsfq_merge_toggle: DEAD_CYCLES must be 0..15");
    end
    if (CNT_W < 1 || CNT_W > 31) begin : g_badCntW
        $error("rsfq_merge_toggle: CNT_W must be 1..31");
    end

    merge_state_t      r_state;
    merge_state_t      w_stateNext;
    logic [DEAD_W-1:0] r_deadCnt;
    logic [DEAD_W-1:0] w_deadNext;
    logic              r_qTgl;
    logic              w_qTglNext;
    logic              r_qPulse;
    logic              w_qPulseNext;
    logic              r_collision;
    logic              w_collisionNext;
    logic              w_detEn;
    logic              w_evA;
    logic              w_evB;
    logic [1:0]        w_nEv;
    logic [1:0]        w_absorb;

    // Events are ignored on the INIT edge so levels present at release are
    // never mistaken for pulses.
    assign w_detEn = (r_state != INIT);

    rsfq_toggle_edge u_edgeA (
        .clk   (clk),
        .rst_n (rst_n),
        .i_tgl (a_tgl),
        .i_en  (w_detEn),
        .o_ev  (w_evA)
    );

    rsfq_toggle_edge u_edgeB (
        .clk   (clk),
        .rst_n (rst_n),
        .i_tgl (b_tgl),
        .i_en  (w_detEn),
        .o_ev  (w_evB)
    );

    assign w_nEv = {1'b0, w_evA} + {1'b0, w_evB};

    // State register plus the registered output pulse, toggle and flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= INIT;
            r_deadCnt   <= '0;
            r_qTgl      <= 1'b0;
            r_qPulse    <= 1'b0;
            r_collision <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_deadCnt   <= w_deadNext;
            r_qTgl      <= w_qTglNext;
            r_qPulse    <= w_qPulseNext;
            r_collision <= w_collisionNext;
        end
    end

    // Next-state logic: emit one output per IDLE event group, then absorb
    // everything until the dead counter runs out. The edge on which the
    // counter reaches zero still belongs to the dead window.
    always_comb begin
        w_stateNext  = r_state;
        w_deadNext   = r_deadCnt;
        w_qTglNext   = r_qTgl;
        w_qPulseNext = 1'b0;
        w_absorb     = 2'd0;

        case (r_state)
            INIT: begin
                w_stateNext = IDLE;
            end

            IDLE: begin
                if (w_nEv != 2'd0) begin
                    w_qTglNext   = ~r_qTgl;
                    w_qPulseNext = 1'b1;
                    if (w_nEv == 2'd2) begin
                        w_absorb = 2'd1;
                    end
                    if (DEAD_CYCLES > 0) begin
                        w_deadNext  = DEAD_W'(DEAD_CYCLES);
                        w_stateNext = DEAD;
                    end
                end
            end

            DEAD: begin
                w_absorb = w_nEv;
                if (r_deadCnt <= DEAD_W'(1)) begin
                    w_deadNext  = '0;
                    w_stateNext = IDLE;
                end else begin
                    w_deadNext = r_deadCnt - DEAD_W'(1);
                end
            end

            default: begin
                w_stateNext = INIT;
                w_deadNext  = '0;
            end
        endcase

        // A fresh absorption wins over a clear request in the same cycle.
        if (w_absorb != 2'd0) begin
            w_collisionNext = 1'b1;
        end else if (clr_coll) begin
            w_collisionNext = 1'b0;
        end else begin
            w_collisionNext = r_collision;
        end
    end

    assign q_tgl     = r_qTgl;
    assign q_pulse   = r_qPulse;
    assign busy      = (r_state == DEAD);
    assign collision = r_collision;

`ifdef RSFQ_MERGE_DROP_CNT_EN
    localparam logic [31:0] DropMax = 32'((64'd1 << CNT_W) - 64'd1);

    logic [CNT_W-1:0] r_dropCnt;

    // Saturating count of absorbed pulses; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dropCnt <= '0;
        end else begin
            r_dropCnt <= CNT_W'(sat_add(32'(r_dropCnt), w_absorb, DropMax));
        end
    end

    assign drop_cnt = r_dropCnt;
`endif

endmodule

// File: tb/tb_rsfq_merge_toggle.sv
// tb_rsfq_merge_toggle: directed, table-driven bench for rsfq_merge_toggle.
// Main DUT uses DEAD_CYCLES=2, CNT_W=2 (so drop_cnt saturates at 3 when
// RSFQ_MERGE_DROP_CNT_EN is defined); a second DUT uses DEAD_CYCLES=0.
module tb_rsfq_merge_toggle;

    logic clk;
    logic rst_n;
    logic a_tgl;
    logic b_tgl;
    logic clr_coll;
    logic q_tgl;
    logic q_pulse;
    logic busy;
    logic collision;

    logic a0;
    logic b0;
    logic clr0;
    logic q0;
    logic p0;
    logic busy0;
    logic coll0;

`ifdef RSFQ_MERGE_DROP_CNT_EN
    logic [1:0] drop_cnt;
    logic [7:0] drop0;
`endif

    int total;
    int bad;

    rsfq_merge_toggle #(.DEAD_CYCLES(2), .CNT_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_tgl     (a_tgl),
        .b_tgl     (b_tgl),
        .clr_coll  (clr_coll),
        .q_tgl     (q_tgl),
        .q_pulse   (q_pulse),
        .busy      (busy),
        .collision (collision)
`ifdef RSFQ_MERGE_DROP_CNT_EN
       ,.drop_cnt  (drop_cnt)
`endif
    );

    rsfq_merge_toggle #(.DEAD_CYCLES(0), .CNT_W(8)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_tgl     (a0),
        .b_tgl     (b0),
        .clr_coll  (clr0),
        .q_tgl     (q0),
        .q_pulse   (p0),
        .busy      (busy0),
        .collision (coll0)
`ifdef RSFQ_MERGE_DROP_CNT_EN
       ,.drop_cnt  (drop0)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic a;
        logic b;
        logic clr;
        logic expQ;
        logic expPulse;
        logic expBusy;
        logic expColl;
        int   expDrop;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs[NV];

    // Compare one value and log any disagreement.
    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive main-DUT inputs, let one edge pass, settle away from the edge.
    task automatic applyStimulus(input logic a, input logic b, input logic clr);
        a_tgl    = a;
        b_tgl    = b;
        clr_coll = clr;
        @(posedge clk);
        #1;
    endtask

    // Check all four main-DUT outputs against expectations.
    task automatic checkMain(input string tag, input logic eq, input logic ep,
                             input logic eb, input logic ec);
        checkOutput({tag, ".q_tgl"},     int'(q_tgl),     int'(eq));
        checkOutput({tag, ".q_pulse"},   int'(q_pulse),   int'(ep));
        checkOutput({tag, ".busy"},      int'(busy),      int'(eb));
        checkOutput({tag, ".collision"}, int'(collision), int'(ec));
    endtask

    // Drive the zero-dead-time DUT for one edge and check it.
    task automatic step0(input string tag, input logic a, input logic b,
                         input logic eq, input logic ep, input logic ec, input int ed);
        a0   = a;
        b0   = b;
        clr0 = 1'b0;
        @(posedge clk);
        #1;
        checkOutput({tag, ".q_tgl"},     int'(q0),    int'(eq));
        checkOutput({tag, ".q_pulse"},   int'(p0),    int'(ep));
        checkOutput({tag, ".busy"},      int'(busy0), 0);
        checkOutput({tag, ".collision"}, int'(coll0), int'(ec));
`ifdef RSFQ_MERGE_DROP_CNT_EN
        checkOutput({tag, ".drop_cnt"},  int'(drop0), ed);
`else
        if (ed < 0) $display("[TB] note: negative drop expectation %0d", ed);
`endif
    endtask

    initial begin
        total = 0;
        bad   = 0;

        //            a  b  clr  q  p  busy coll drop
        vecs[0]  = '{1, 0, 0,   0, 0, 0, 0, 0};   // INIT edge, level 1 ignored
        vecs[1]  = '{1, 0, 0,   0, 0, 0, 0, 0};
        vecs[2]  = '{1, 0, 0,   0, 0, 0, 0, 0};
        vecs[3]  = '{0, 0, 0,   1, 1, 1, 0, 0};   // A pulse -> output
        vecs[4]  = '{0, 0, 0,   1, 0, 1, 0, 0};
        vecs[5]  = '{0, 0, 0,   1, 0, 0, 0, 0};   // dead window ends
        vecs[6]  = '{1, 0, 0,   0, 1, 1, 0, 0};   // earliest next output
        vecs[7]  = '{1, 0, 0,   0, 0, 1, 0, 0};
        vecs[8]  = '{1, 0, 0,   0, 0, 0, 0, 0};
        vecs[9]  = '{0, 1, 0,   1, 1, 1, 1, 1};   // A and B together
        vecs[10] = '{0, 1, 0,   1, 0, 1, 1, 1};
        vecs[11] = '{0, 0, 0,   1, 0, 0, 1, 2};   // B absorbed on last dead edge
        vecs[12] = '{0, 0, 1,   1, 0, 0, 0, 2};   // clear with no event
        vecs[13] = '{1, 0, 0,   0, 1, 1, 0, 2};
        vecs[14] = '{1, 1, 0,   0, 0, 1, 1, 3};   // B absorbed
        vecs[15] = '{0, 1, 1,   0, 0, 0, 1, 3};   // set beats clear, saturated
        vecs[16] = '{0, 1, 0,   0, 0, 0, 1, 3};
        vecs[17] = '{0, 1, 1,   0, 0, 0, 0, 3};
        vecs[18] = '{1, 1, 0,   1, 1, 1, 0, 3};   // A out
        vecs[19] = '{1, 1, 0,   1, 0, 1, 0, 3};
        vecs[20] = '{1, 0, 0,   1, 0, 0, 1, 3};   // B two edges later absorbed
        vecs[21] = '{1, 0, 0,   1, 0, 0, 1, 3};
        vecs[22] = '{1, 1, 0,   0, 1, 1, 1, 3};   // B again -> output
        vecs[23] = '{1, 1, 0,   0, 0, 1, 1, 3};
        vecs[24] = '{1, 1, 0,   0, 0, 0, 1, 3};
        vecs[25] = '{0, 1, 0,   1, 1, 1, 1, 3};   // DEAD_CYCLES+1 edges later

        rst_n    = 1'b0;
        a_tgl    = 1'b1;
        b_tgl    = 1'b0;
        clr_coll = 1'b0;
        a0       = 1'b0;
        b0       = 1'b0;
        clr0     = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkMain("reset", 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef RSFQ_MERGE_DROP_CNT_EN
        checkOutput("reset.drop_cnt", int'(drop_cnt), 0);
`endif
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].clr);
            checkMain($sformatf("v%0d", i), vecs[i].expQ, vecs[i].expPulse,
                      vecs[i].expBusy, vecs[i].expColl);
`ifdef RSFQ_MERGE_DROP_CNT_EN
            checkOutput($sformatf("v%0d.drop_cnt", i), int'(drop_cnt), vecs[i].expDrop);
`endif
        end

        // Reset while busy: outputs clear immediately, no output afterwards.
        checkOutput("preRst.busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        checkMain("midRst", 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef RSFQ_MERGE_DROP_CNT_EN
        checkOutput("midRst.drop_cnt", int'(drop_cnt), 0);
`endif
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            checkMain($sformatf("postRst%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkMain("postRstPulse", 1'b1, 1'b1, 1'b1, 1'b0);

        // Zero dead time: every edge with an event emits.
        step0("z0", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        step0("z1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        step0("z2", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        step0("z3", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        step0("z4", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1);
        step0("z5", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
